// File: rtl/vend_credit_ctrl.sv
// Coin-credit and vend controller: keeps the running credit, arbitrates coin,
// selection and cancel events, sequences dispense and change return, and drives
// the load strobes of the downstream credit display register bank.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no credit held; coins accepted, selections refused
// COLLECT | credit > 0; coins, selections and cancel accepted
// VEND    | dispense_valid held for DISP_CYCLES; all inputs refused
// REFUND  | change_valid held with change_amount until change_ack
module vend_credit_ctrl #(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned MAX_CREDIT  = 95,
  parameter int unsigned PRICE0      = 15,
  parameter int unsigned PRICE1      = 20,
  parameter int unsigned PRICE2      = 25,
  parameter int unsigned PRICE3      = 30,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                insuf,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] reg_d,
  output logic                reg_en,
  output logic                reg_l
);

  localparam int unsigned CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                coin_rej_q, coin_rej_d;
  logic                insuf_q, insuf_d;
  logic                disp_valid_q, disp_valid_d;
  logic [1:0]          disp_item_q, disp_item_d;
  logic                chg_valid_q, chg_valid_d;
  logic [CREDIT_W-1:0] chg_amount_q, chg_amount_d;
  logic [CREDIT_W-1:0] reg_d_q, reg_d_d;
  logic                reg_l_q, reg_l_d;
  logic                reg_en_q;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] price;

  // Coin value and the widened sum so an overflowing coin can never wrap.
  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'b00:   coin_val = (CREDIT_W+1)'(5);
      2'b01:   coin_val = (CREDIT_W+1)'(10);
      2'b10:   coin_val = (CREDIT_W+1)'(25);
      default: coin_val = '0;
    endcase
    coin_sum = {1'b0, credit_q} + coin_val;
    coin_ok  = (coin_type != 2'b11) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  end

  // Price lookup for the selected item.
  always_comb begin
    price = '0;
    case (sel_item)
      2'd0:    price = CREDIT_W'(PRICE0);
      2'd1:    price = CREDIT_W'(PRICE1);
      2'd2:    price = CREDIT_W'(PRICE2);
      default: price = CREDIT_W'(PRICE3);
    endcase
  end

  // Next-state and registered-output computation with event priority cancel > sel > coin.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    cnt_d        = cnt_q;
    coin_rej_d   = 1'b0;
    insuf_d      = 1'b0;
    disp_valid_d = disp_valid_q;
    disp_item_d  = disp_item_q;
    chg_valid_d  = chg_valid_q;
    chg_amount_d = chg_amount_q;
    reg_d_d      = reg_d_q;
    reg_l_d      = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (cancel && state_q == COLLECT) begin
          state_d      = REFUND;
          chg_valid_d  = 1'b1;
          chg_amount_d = credit_q;
          coin_rej_d   = coin_valid;
        end else if (sel_valid) begin
          coin_rej_d = coin_valid;
          if (state_q == COLLECT && credit_q >= price) begin
            credit_d     = credit_q - price;
            disp_item_d  = sel_item;
            disp_valid_d = 1'b1;
            cnt_d        = CNT_W'(DISP_CYCLES - 1);
            state_d      = VEND;
          end else begin
            insuf_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
      end
      VEND: begin
        coin_rej_d = coin_valid;
        if (cnt_q == '0) begin
          disp_valid_d = 1'b0;
          if (credit_q != '0) begin
            state_d      = REFUND;
            chg_valid_d  = 1'b1;
            chg_amount_d = credit_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        coin_rej_d = coin_valid;
        if (change_ack) begin
          credit_d    = '0;
          chg_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase

    // Display register loads exactly when the credit value moves.
    if (credit_d != credit_q) begin
      reg_l_d = 1'b1;
      reg_d_d = credit_d;
    end
  end

  // State and output registers; reset aborts any vend or refund in flight.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      cnt_q        <= '0;
      coin_rej_q   <= 1'b0;
      insuf_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_item_q  <= 2'd0;
      chg_valid_q  <= 1'b0;
      chg_amount_q <= '0;
      reg_d_q      <= '0;
      reg_l_q      <= 1'b0;
      reg_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      cnt_q        <= cnt_d;
      coin_rej_q   <= coin_rej_d;
      insuf_q      <= insuf_d;
      disp_valid_q <= disp_valid_d;
      disp_item_q  <= disp_item_d;
      chg_valid_q  <= chg_valid_d;
      chg_amount_q <= chg_amount_d;
      reg_d_q      <= reg_d_d;
      reg_l_q      <= reg_l_d;
      reg_en_q     <= 1'b1;
    end
  end

  assign credit         = credit_q;
  assign coin_rej       = coin_rej_q;
  assign insuf          = insuf_q;
  assign dispense_valid = disp_valid_q;
  assign dispense_item  = disp_item_q;
  assign change_valid   = chg_valid_q;
  assign change_amount  = chg_amount_q;
  assign reg_d          = reg_d_q;
  assign reg_l          = reg_l_q;
  assign reg_en         = reg_en_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of credit and dispense.
module tb_vend_credit_ctrl;

  localparam int DISP = 4;
  localparam int MAXC = 95;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [7:0] credit;
  logic       coin_rej;
  logic       insuf;
  logic       dispense_valid;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [7:0] change_amount;
  logic [7:0] reg_d;
  logic       reg_en;
  logic       reg_l;

  vend_credit_ctrl dut (
    .CLK(CLK), .CLR(CLR),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel), .change_ack(change_ack),
    .credit(credit), .coin_rej(coin_rej), .insuf(insuf),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amount(change_amount),
    .reg_d(reg_d), .reg_en(reg_en), .reg_l(reg_l)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: credit plus remaining dispense time and pending refund.
  int price[4] = '{15, 20, 25, 30};
  int m_credit, m_vend_left, m_chg, m_item, m_reg_d;
  bit m_refund, m_rej, m_insuf, m_reg_l, m_reg_en;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_vend_left = 0; m_chg = 0; m_item = 0; m_reg_d = 0;
    m_refund = 0; m_rej = 0; m_insuf = 0; m_reg_l = 0; m_reg_en = 0;
  endtask

  function automatic int coin_cents(input bit [1:0] t);
    case (t)
      2'd0: return 5;
      2'd1: return 10;
      2'd2: return 25;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit cv, input bit [1:0] ct, input bit sv,
                            input bit [1:0] si, input bit cn, input bit ack);
    int old = m_credit;
    m_rej = 0; m_insuf = 0;
    if (m_vend_left > 0) begin
      m_rej = cv;
      m_vend_left--;
      if (m_vend_left == 0 && m_credit > 0) begin
        m_refund = 1; m_chg = m_credit;
      end
    end else if (m_refund) begin
      m_rej = cv;
      if (ack) begin m_credit = 0; m_refund = 0; end
    end else if (cn && m_credit > 0) begin
      m_refund = 1; m_chg = m_credit; m_rej = cv;
    end else if (sv) begin
      m_rej = cv;
      if (m_credit >= price[si]) begin
        m_credit -= price[si]; m_item = si; m_vend_left = DISP;
      end else m_insuf = 1;
    end else if (cv) begin
      if (ct != 2'd3 && m_credit + coin_cents(ct) <= MAXC) m_credit += coin_cents(ct);
      else m_rej = 1;
    end
    m_reg_l = (m_credit != old);
    if (m_reg_l) m_reg_d = m_credit;
    m_reg_en = 1;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".credit"}, credit, m_credit);
    check_eq({tag, ".coin_rej"}, coin_rej, m_rej);
    check_eq({tag, ".insuf"}, insuf, m_insuf);
    check_eq({tag, ".disp_valid"}, dispense_valid, m_vend_left > 0);
    check_eq({tag, ".disp_item"}, dispense_item, m_item);
    check_eq({tag, ".chg_valid"}, change_valid, m_refund);
    check_eq({tag, ".chg_amount"}, change_amount, m_chg);
    check_eq({tag, ".reg_d"}, reg_d, m_reg_d);
    check_eq({tag, ".reg_l"}, reg_l, m_reg_l);
    check_eq({tag, ".reg_en"}, reg_en, m_reg_en);
  endtask

  task automatic step(input string tag, input bit cv, input bit [1:0] ct, input bit sv,
                      input bit [1:0] si, input bit cn, input bit ack);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel_item = si;
    cancel = cn; change_ack = ack;
    @(posedge CLK);
    model_step(cv, ct, sv, si, cn, ack);
    #1;
    coin_valid = 0; sel_valid = 0; cancel = 0; change_ack = 0;
    compare_all(tag);
  endtask

  task automatic coin(input string tag, input bit [1:0] ct);
    step(tag, 1, ct, 0, 0, 0, 0);
  endtask

  task automatic sel(input string tag, input bit [1:0] si);
    step(tag, 0, 0, 1, si, 0, 0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12 CLR = 0;
    #7;
    idle("por", 1);

    // Exact vend: 10 + 10, item 1 at 20, ends in idle with no change.
    coin("t2_c10a", 2'd1);
    check_eq("t2_credit10", credit, 10);
    coin("t2_c10b", 2'd1);
    check_eq("t2_credit20", credit, 20);
    sel("t2_sel1", 2'd1);
    check_eq("t2_credit0", credit, 0);
    idle("t2_vend", 6);

    // Vend with change: 25 + 25, item 3 at 30, change 20 held until ack.
    coin("t3_c25a", 2'd2);
    coin("t3_c25b", 2'd2);
    sel("t3_sel3", 2'd3);
    idle("t3_vend", 4);
    check_eq("t3_chg_amount", change_amount, 20);
    idle("t3_hold", 5);
    step("t3_ack", 0, 0, 0, 0, 0, 1);
    idle("t3_after", 1);

    // Overflow and invalid coins around MAX_CREDIT.
    coin("t4_c25a", 2'd2);
    coin("t4_c25b", 2'd2);
    coin("t4_c25c", 2'd2);
    coin("t4_ovf25", 2'd2);
    coin("t4_bad", 2'd3);
    coin("t4_c10a", 2'd1);
    coin("t4_c10b", 2'd1);
    check_eq("t4_credit95", credit, 95);
    coin("t4_ovf5", 2'd0);
    step("t4_cancel", 0, 0, 0, 0, 1, 0);
    step("t4_ack", 0, 0, 0, 0, 0, 1);

    // Simultaneous events: cancel wins over selection and coin.
    coin("t5_c10", 2'd1);
    coin("t5_c5", 2'd0);
    step("t5_all", 1, 2'd0, 1, 2'd0, 1, 0);
    check_eq("t5_rej", coin_rej, 1);
    idle("t5_hold", 2);
    step("t5_ack", 0, 0, 0, 0, 0, 1);
    coin("t5_c10b", 2'd1);
    sel("t5_insuf", 2'd2);
    check_eq("t5_insuf_pulse", insuf, 1);
    step("t5_cancel", 0, 0, 0, 0, 1, 0);
    step("t5_ack2", 0, 0, 0, 0, 0, 1);
    sel("t5_idle_sel", 2'd0);

    // Busy rejects during vend and refund.
    coin("t6_c25", 2'd2);
    sel("t6_sel0", 2'd0);
    coin("t6_vend_coin", 2'd1);
    step("t6_vend_cancel", 0, 0, 0, 0, 1, 0);
    idle("t6_vend", 3);
    coin("t6_ref_coin", 2'd0);
    step("t6_ack", 0, 0, 0, 0, 0, 1);

    // Reset mid-vend: outputs clear immediately, reg_en returns after first edge.
    coin("t1_c10a", 2'd1);
    coin("t1_c10b", 2'd1);
    coin("t1_c5", 2'd0);
    sel("t1_sel1", 2'd1);
    idle("t1_vend", 1);
    CLR = 1;
    #1;
    check_eq("t1_rst_credit", credit, 0);
    check_eq("t1_rst_disp", dispense_valid, 0);
    check_eq("t1_rst_item", dispense_item, 0);
    check_eq("t1_rst_chg", change_valid, 0);
    check_eq("t1_rst_reg_d", reg_d, 0);
    check_eq("t1_rst_reg_en", reg_en, 0);
    model_reset();
    @(negedge CLK);
    CLR = 0;
    idle("t1_post", 1);
    check_eq("t1_reg_en", reg_en, 1);
    idle("t1_quiet", 5);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step("rnd", $urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
